updown_mod_counter: RTL and testbench

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

---
 rtl/updown_mod_counter.sv | 52 +++++
 tb/tb_updown_mod_counter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: up/down modulo counter with load, clamp-to-limit, terminal-count pulse and sticky boundary flag
module updown_mod_counter #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             at_top, at_bot, bnd;
  logic [WIDTH-1:0] up_next, dn_next, load_next;
  assign at_top    = count_q >= max_val;
  assign at_bot    = count_q == ZERO;
  assign bnd       = up_dn ? at_top : at_bot;
  assign load_next = (load_val > max_val) ? max_val : load_val;
  assign up_next   = at_top ? (SATURATE ? max_val : ZERO) : count_q + ONE;
  assign dn_next   = at_bot ? (SATURATE ? ZERO : max_val) : (count_q > max_val) ? max_val : count_q - ONE;
  // next state: clear beats load beats an enabled step; otherwise hold with tc low
  always_comb begin
    count_d = clear ? ZERO : load ? load_next : en ? (up_dn ? up_next : dn_next) : count_q;
    tc_d    = !clear && !load && en && bnd;
    ovf_d   = !clear && (ovf_q || (!load && en && bnd));
  end
  // state registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end
  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: directed checks of a wrap-mode and a saturate-mode counter driven in parallel
module tb_updown_mod_counter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] max_val = 4'd9;
  logic [3:0] cnt_w, cnt_s;
  logic       tc_w, tc_s, ovf_w, ovf_s;
  logic [11:0] obs;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign obs = {cnt_w, tc_w, ovf_w, cnt_s, tc_s, ovf_s};

  updown_mod_counter #(.WIDTH(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .clear(clear), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .max_val(max_val), .count(cnt_w), .tc(tc_w), .ovf(ovf_w));

  updown_mod_counter #(.WIDTH(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .clear(clear), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .max_val(max_val), .count(cnt_s), .tc(tc_s), .ovf(ovf_s));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; load = 1'b0; en = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    n_chk++;
    if (obs !== 12'h000) begin n_fail++; $display("FAIL reset_async: got %h exp %h", obs, 12'h000); end
    en = 1'b1; up_dn = 1'b1;
    tick();
    n_chk++;
    if (obs !== 12'h000) begin n_fail++; $display("FAIL reset_held: got %h exp %h", obs, 12'h000); end
    en = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_wrap_up();
    logic [11:0] exp;
    reset = 1'b1; #2; reset = 1'b0;
    max_val = 4'd9; en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp = {4'(i % 10), i == 10, i >= 10, 4'(i <= 9 ? i : 9), i >= 10, i >= 10};
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL wrap_up[%0d]: got %h exp %h", i, obs, exp); end
    end
    en = 1'b0;
  endtask

  task automatic test_wrap_down();
    do_clear();
    max_val = 4'd5; en = 1'b1; up_dn = 1'b0;
    tick();
    n_chk++;
    if (obs !== {4'd5, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1}) begin n_fail++; $display("FAIL down_bnd: got %h exp %h", obs, {4'd5, 2'b11, 4'd0, 2'b11}); end
    tick();
    n_chk++;
    if (obs !== {4'd4, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1}) begin n_fail++; $display("FAIL down_next: got %h exp %h", obs, {4'd4, 2'b01, 4'd0, 2'b11}); end
    tick();
    n_chk++;
    if (obs !== {4'd3, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1}) begin n_fail++; $display("FAIL down_hold: got %h exp %h", obs, {4'd3, 2'b01, 4'd0, 2'b11}); end
    en = 1'b0;
  endtask

  task automatic test_priority();
    clear = 1'b1; load = 1'b1; load_val = 4'd3; en = 1'b1; up_dn = 1'b1;
    tick();
    n_chk++;
    if (obs !== 12'h000) begin n_fail++; $display("FAIL prio_clear: got %h exp %h", obs, 12'h000); end
    clear = 1'b0; max_val = 4'd9; load_val = 4'd12;
    tick();
    n_chk++;
    if (obs !== {4'd9, 2'b00, 4'd9, 2'b00}) begin n_fail++; $display("FAIL prio_load_clamp: got %h exp %h", obs, {4'd9, 2'b00, 4'd9, 2'b00}); end
    load_val = 4'd4; up_dn = 1'b0;
    tick();
    n_chk++;
    if (obs !== {4'd4, 2'b00, 4'd4, 2'b00}) begin n_fail++; $display("FAIL prio_load_en: got %h exp %h", obs, {4'd4, 2'b00, 4'd4, 2'b00}); end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_limit_change();
    do_clear();
    max_val = 4'd9;
    do_load(4'd8);
    max_val = 4'd5; en = 1'b1; up_dn = 1'b1;
    tick();
    n_chk++;
    if (obs !== {4'd0, 2'b11, 4'd5, 2'b11}) begin n_fail++; $display("FAIL limit_up: got %h exp %h", obs, {4'd0, 2'b11, 4'd5, 2'b11}); end
    en = 1'b0;
    do_clear();
    max_val = 4'd9;
    do_load(4'd8);
    max_val = 4'd5; en = 1'b1; up_dn = 1'b0;
    tick();
    n_chk++;
    if (obs !== {4'd5, 2'b00, 4'd5, 2'b00}) begin n_fail++; $display("FAIL limit_down: got %h exp %h", obs, {4'd5, 2'b00, 4'd5, 2'b00}); end
    en = 1'b0;
  endtask

  task automatic test_async_reset();
    do_clear();
    max_val = 4'd9;
    do_load(4'd7);
    n_chk++;
    if (obs !== {4'd7, 2'b00, 4'd7, 2'b00}) begin n_fail++; $display("FAIL areset_pre: got %h exp %h", obs, {4'd7, 2'b00, 4'd7, 2'b00}); end
    en = 1'b1; up_dn = 1'b1;
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if (obs !== 12'h000) begin n_fail++; $display("FAIL areset_mid: got %h exp %h", obs, 12'h000); end
    #2 reset = 1'b0;
    tick();
    n_chk++;
    if (obs !== {4'd1, 2'b00, 4'd1, 2'b00}) begin n_fail++; $display("FAIL areset_step: got %h exp %h", obs, {4'd1, 2'b00, 4'd1, 2'b00}); end
    en = 1'b0;
  endtask

  task automatic test_idle_hold();
    do_clear();
    max_val = 4'd9; en = 1'b1; up_dn = 1'b0;
    tick();
    en = 1'b0;
    do_load(4'd3);
    for (int i = 0; i < 10; i++) begin
      tick();
      n_chk++;
      if (obs !== {4'd3, 2'b01, 4'd3, 2'b01}) begin n_fail++; $display("FAIL idle[%0d]: got %h exp %h", i, obs, {4'd3, 2'b01, 4'd3, 2'b01}); end
    end
  endtask

  task automatic test_max_zero();
    do_clear();
    max_val = 4'd0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_dn = i[0];
      tick();
      n_chk++;
      if (obs !== {4'd0, 2'b11, 4'd0, 2'b11}) begin n_fail++; $display("FAIL max_zero[%0d]: got %h exp %h", i, obs, {4'd0, 2'b11, 4'd0, 2'b11}); end
    end
    en = 1'b0;
    tick();
    n_chk++;
    if (obs !== {4'd0, 2'b01, 4'd0, 2'b01}) begin n_fail++; $display("FAIL max_zero_idle: got %h exp %h", obs, {4'd0, 2'b01, 4'd0, 2'b01}); end
    do_clear();
    n_chk++;
    if (obs !== 12'h000) begin n_fail++; $display("FAIL clear_ovf: got %h exp %h", obs, 12'h000); end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_priority();
    test_limit_change();
    test_async_reset();
    test_idle_hold();
    test_max_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
